// File: rtl/wt_mem_req_arbiter.sv
// wt_mem_req_arbiter: round-robin merge of I$/D$ requests into one registered memory channel, with return routing.
// Optional perf counters enabled by defining WT_MEM_ARB_PERF_CNT_EN.
module wt_mem_req_arbiter #(
  parameter int AddrWidth      = 64,
  parameter int DataWidth      = 64,
  parameter int RtrnWidth      = 128,
  parameter int TidWidth       = 2,
  parameter int MaxOutstanding = 4
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 icache_data_req_i,
  output logic                 icache_data_ack_o,
  input  logic [AddrWidth-1:0] icache_paddr_i,
  input  logic [TidWidth-1:0]  icache_tid_i,
  input  logic                 dcache_data_req_i,
  output logic                 dcache_data_ack_o,
  input  logic [1:0]           dcache_rtype_i,
  input  logic [AddrWidth-1:0] dcache_paddr_i,
  input  logic [2:0]           dcache_size_i,
  input  logic [DataWidth-1:0] dcache_data_i,
  input  logic [TidWidth-1:0]  dcache_tid_i,
  output logic                 mem_req_valid_o,
  input  logic                 mem_req_ready_i,
  output logic [1:0]           mem_req_rtype_o,
  output logic [AddrWidth-1:0] mem_req_paddr_o,
  output logic [2:0]           mem_req_size_o,
  output logic [DataWidth-1:0] mem_req_data_o,
  output logic [TidWidth:0]    mem_req_tid_o,
  input  logic                 mem_rtrn_vld_i,
  input  logic [TidWidth:0]    mem_rtrn_tid_i,
  input  logic [RtrnWidth-1:0] mem_rtrn_data_i,
  output logic                 icache_rtrn_vld_o,
  output logic                 dcache_rtrn_vld_o,
  output logic [TidWidth-1:0]  rtrn_tid_o,
  output logic [RtrnWidth-1:0] rtrn_data_o,
`ifdef WT_MEM_ARB_PERF_CNT_EN
  output logic [31:0]          perf_igrant_o,
  output logic [31:0]          perf_dgrant_o,
  output logic [31:0]          perf_stall_o,
`endif
  output logic                 busy_o,
  output logic                 err_o
);
  localparam int CntW = $clog2(MaxOutstanding + 1);
  logic                 valid_q, valid_d;
  logic [1:0]           rtype_q, rtype_d;
  logic [AddrWidth-1:0] paddr_q, paddr_d;
  logic [2:0]           size_q, size_d;
  logic [DataWidth-1:0] data_q, data_d;
  logic [TidWidth:0]    tid_q, tid_d;
  logic                 rr_q, rr_d;
  logic [CntW-1:0]      icnt_q, icnt_d, dcnt_q, dcnt_d;
  logic                 err_q, err_d;
  logic can_load, i_elig, d_elig, igrant, dgrant, iret, dret, idec, ddec;
  // rr_q=0 favours I$; acks and returns are suppressed while reset is asserted
  always_comb begin
    can_load = !valid_q | mem_req_ready_i;
    i_elig   = icache_data_req_i & (icnt_q < CntW'(MaxOutstanding)) & can_load & !rst_i;
    d_elig   = dcache_data_req_i & (dcnt_q < CntW'(MaxOutstanding)) & can_load & !rst_i;
    igrant   = i_elig & (!d_elig | !rr_q);
    dgrant   = d_elig & (!i_elig | rr_q);
    rr_d     = (i_elig & d_elig) ? igrant : rr_q;
    valid_d  = igrant | dgrant | (valid_q & !mem_req_ready_i);
    rtype_d  = igrant ? 2'd0 : dgrant ? dcache_rtype_i + 2'd1 : rtype_q;
    paddr_d  = igrant ? icache_paddr_i : dgrant ? dcache_paddr_i : paddr_q;
    size_d   = igrant ? 3'b100 : dgrant ? dcache_size_i : size_q;
    data_d   = igrant ? '0 : dgrant ? dcache_data_i : data_q;
    tid_d    = igrant ? {1'b0, icache_tid_i} : dgrant ? {1'b1, dcache_tid_i} : tid_q;
    iret     = mem_rtrn_vld_i & !mem_rtrn_tid_i[TidWidth] & !rst_i;
    dret     = mem_rtrn_vld_i & mem_rtrn_tid_i[TidWidth] & !rst_i;
    idec     = iret & (icnt_q != '0);
    ddec     = dret & (dcnt_q != '0);
    icnt_d   = icnt_q + CntW'(igrant) - CntW'(idec);
    dcnt_d   = dcnt_q + CntW'(dgrant) - CntW'(ddec);
    err_d    = err_q | (iret & (icnt_q == '0)) | (dret & (dcnt_q == '0));
  end
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      valid_q <= 1'b0;
      rtype_q <= '0;
      paddr_q <= '0;
      size_q  <= '0;
      data_q  <= '0;
      tid_q   <= '0;
      rr_q    <= 1'b0;
      icnt_q  <= '0;
      dcnt_q  <= '0;
      err_q   <= 1'b0;
    end else begin
      valid_q <= valid_d;
      rtype_q <= rtype_d;
      paddr_q <= paddr_d;
      size_q  <= size_d;
      data_q  <= data_d;
      tid_q   <= tid_d;
      rr_q    <= rr_d;
      icnt_q  <= icnt_d;
      dcnt_q  <= dcnt_d;
      err_q   <= err_d;
    end
  end
`ifdef WT_MEM_ARB_PERF_CNT_EN
  logic [31:0] pig_q, pdg_q, pst_q;
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      pig_q <= '0;
      pdg_q <= '0;
      pst_q <= '0;
    end else begin
      pig_q <= pig_q + 32'(igrant);
      pdg_q <= pdg_q + 32'(dgrant);
      pst_q <= pst_q + 32'(valid_q & !mem_req_ready_i);
    end
  end
  assign perf_igrant_o = pig_q;
  assign perf_dgrant_o = pdg_q;
  assign perf_stall_o  = pst_q;
`endif
  assign icache_data_ack_o = igrant;
  assign dcache_data_ack_o = dgrant;
  assign mem_req_valid_o   = valid_q;
  assign mem_req_rtype_o   = rtype_q;
  assign mem_req_paddr_o   = paddr_q;
  assign mem_req_size_o    = size_q;
  assign mem_req_data_o    = data_q;
  assign mem_req_tid_o     = tid_q;
  assign icache_rtrn_vld_o = iret;
  assign dcache_rtrn_vld_o = dret;
  assign rtrn_tid_o        = rst_i ? '0 : mem_rtrn_tid_i[TidWidth-1:0];
  assign rtrn_data_o       = rst_i ? '0 : mem_rtrn_data_i;
  assign busy_o            = valid_q | (icnt_q != '0) | (dcnt_q != '0);
  assign err_o             = err_q;
endmodule
